// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared default sizing for the RAM family
//
// Purpose: default word width and address width used by ram_sdp and ram_fifo.
// Ports:   none (package).

package ram_pkg;

    localparam int RAM_DATA_WIDTH = 8;
    localparam int RAM_ADDR_WIDTH = 5;

endpackage

// File: rtl/ram_sdp.sv
// rtl/ram_sdp.sv - single-clock simple-dual-port RAM with registered read port
//
// Purpose: storage array for ram_fifo. One write port, one read port whose
//          output register loads only on an enabled read.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high, clears the read register only
//   wr_en_i    in   write enable
//   wr_addr_i  in   write address
//   wr_data_i  in   write data
//   rd_en_i    in   read enable
//   rd_addr_i  in   read address
//   rd_data_o  out  registered read data, held when rd_en_i is low

module ram_sdp
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // The array itself is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ram_fifo.sv
// rtl/ram_fifo.sv - single-clock FIFO on a simple-dual-port RAM
//
// Purpose: in-order word buffer with one-cycle registered read latency,
//          occupancy count, full/empty flags and sticky error flags.
// Ports:
//   clk           in   clock
//   reset         in   synchronous active-high reset
//   write_enable  in   write request
//   data_write    in   word to store
//   read_enable   in   read request
//   data_read     out  registered read data
//   data_valid    out  data_read holds a freshly popped word
//   full          out  count == DEPTH
//   empty         out  count == 0
//   count         out  occupancy 0..DEPTH
//   overflow      out  sticky: write requested while full
//   underflow     out  sticky: read requested while empty

module ram_fifo
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] data_write,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] data_read,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  data_valid_q;
    logic                  full_w, empty_w;
    logic                  wr_acc, rd_acc;

    // Flags come straight off the count register, so no request input
    // reaches full/empty combinationally.
    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);

    always_comb begin
        // Reset gates acceptance so the RAM is not written in a reset cycle.
        wr_acc      = !reset && write_enable && !full_w;
        rd_acc      = !reset && read_enable && !empty_w;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (write_enable & full_w);
        underflow_d = underflow_q | (read_enable & empty_w);

        // Pointers wrap naturally at DEPTH because they are ADDR_WIDTH wide.
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE_C;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE_C;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            data_valid_q <= rd_acc;
        end
    end

    ram_sdp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (data_write),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (data_read)
    );

    assign data_valid = data_valid_q;
    assign full       = full_w;
    assign empty      = empty_w;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_ram_fifo.sv
// tb/tb_ram_fifo.sv - self-checking bench for ram_fifo

module tb_ram_fifo;

    logic       clk;
    logic       reset;
    logic       write_enable;
    logic [7:0] data_write;
    logic       read_enable;
    logic [7:0] data_read;
    logic       data_valid;
    logic       full;
    logic       empty;
    logic [5:0] count;
    logic       overflow;
    logic       underflow;

    int n_vec = 0;
    int n_err = 0;

    ram_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .data_write   (data_write),
        .read_enable  (read_enable),
        .data_read    (data_read),
        .data_valid   (data_valid),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic [5:0] cnt;
        logic       dv;
        logic [7:0] dr;
        logic       ful;
        logic       emp;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic we, input logic [7:0] wd, input logic re);
        @(negedge clk);
        reset        = r;
        write_enable = we;
        data_write   = wd;
        read_enable  = re;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] words[32];
    logic [7:0] sb[$];
    logic [7:0] exp_w;
    logic [7:0] v;

    initial begin
        reset        = 1'b1;
        write_enable = 1'b0;
        data_write   = 8'h00;
        read_enable  = 1'b0;

        //                 rst   we    wd     re    cnt   dv    dr     ful   emp   ovf   unf
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 6'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 8'h11, 1'b1, 6'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 6'd0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 8'h22, 1'b0, 6'd1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 8'h33, 1'b1, 6'd1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 6'd0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 6'd0, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 8'h44, 1'b1, 6'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'h55, 1'b0, 6'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 6'd0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset then idle
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_dv", int'(data_valid), 0);
        chk("rst_dr", int'(data_read), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_unf", int'(underflow), 0);

        // Table: empty read, simultaneous on empty, hold, pass-through, reset dominance
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].rst, vecs[i].we, vecs[i].wd, vecs[i].re);
            chk($sformatf("vec%0d_count", i), int'(count), int'(vecs[i].cnt));
            chk($sformatf("vec%0d_dv", i), int'(data_valid), int'(vecs[i].dv));
            chk($sformatf("vec%0d_dr", i), int'(data_read), int'(vecs[i].dr));
            chk($sformatf("vec%0d_full", i), int'(full), int'(vecs[i].ful));
            chk($sformatf("vec%0d_empty", i), int'(empty), int'(vecs[i].emp));
            chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(vecs[i].ovf));
            chk($sformatf("vec%0d_unf", i), int'(underflow), int'(vecs[i].unf));
        end

        // 27 words 00..1A then C5, read back 28
        for (int i = 0; i < 27; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
        step(1'b0, 1'b1, 8'hC5, 1'b0);
        chk("c5_count28", int'(count), 28);
        for (int i = 0; i < 28; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            exp_w = (i == 27) ? 8'hC5 : 8'(i);
            chk($sformatf("c5_dv%0d", i), int'(data_valid), 1);
            chk($sformatf("c5_dr%0d", i), int'(data_read), int'(exp_w));
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("c5_dv_end", int'(data_valid), 0);
        chk("c5_count_end", int'(count), 0);
        chk("c5_empty_end", int'(empty), 1);

        // Fill to full, overflow, simultaneous on full, readback
        for (int i = 0; i < 32; i++) begin
            words[i] = 8'(i * 7 + 3);
            step(1'b0, 1'b1, words[i], 1'b0);
        end
        chk("fill_count", int'(count), 32);
        chk("fill_full", int'(full), 1);
        chk("fill_ovf_pre", int'(overflow), 0);
        step(1'b0, 1'b1, 8'hFF, 1'b0);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(count), 32);
        step(1'b0, 1'b1, 8'hEE, 1'b1);
        chk("fullrw_count", int'(count), 31);
        chk("fullrw_full", int'(full), 0);
        chk("fullrw_dv", int'(data_valid), 1);
        chk("fullrw_dr", int'(data_read), int'(words[0]));
        for (int i = 1; i < 32; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk($sformatf("fill_dr%0d", i), int'(data_read), int'(words[i]));
        end
        chk("fill_empty_end", int'(empty), 1);
        chk("fill_ovf_sticky", int'(overflow), 1);

        // Streaming across pointer wrap at constant occupancy
        step(1'b1, 1'b0, 8'h00, 1'b0);
        v = 8'h80;
        for (int i = 0; i < 16; i++) begin
            sb.push_back(v);
            step(1'b0, 1'b1, v, 1'b0);
            v = v + 8'd1;
        end
        chk("wrap_count_pre", int'(count), 16);
        for (int i = 0; i < 100; i++) begin
            sb.push_back(v);
            step(1'b0, 1'b1, v, 1'b1);
            v = v + 8'd1;
            exp_w = sb.pop_front();
            chk($sformatf("wrap_count%0d", i), int'(count), 16);
            chk($sformatf("wrap_dv%0d", i), int'(data_valid), 1);
            chk($sformatf("wrap_dr%0d", i), int'(data_read), int'(exp_w));
        end

        // Reset mid-stream with a read in the reset cycle
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(i + 8'h40), 1'b0);
        chk("mid_count10", int'(count), 10);
        chk("mid_unf_pre", int'(underflow), 1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        chk("mid_count", int'(count), 0);
        chk("mid_empty", int'(empty), 1);
        chk("mid_full", int'(full), 0);
        chk("mid_dv", int'(data_valid), 0);
        chk("mid_ovf", int'(overflow), 0);
        chk("mid_unf", int'(underflow), 0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("mid_dv_after", int'(data_valid), 0);
        chk("mid_dr_after", int'(data_read), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
